flash_byte_logger: RTL and testbench
====================================

# flash_byte_logger

Upstream sequencer for the W25Q128 byte-access controller. It buffers incoming bytes in a small FIFO and commits each one to flash at an auto-incrementing address with one write transaction. Random-address readback requests are served between writes. It is the only block that drives the controller's `write_trigger`/`read_trigger`, `flash_addr` and `write_byte`.

## Interface
- `FIFO_DEPTH`, 16: input buffer depth in bytes; must be a power of 2, ≥2.
- `BASE_ADDR`, 24'h000000: first flash address written after reset.
- `END_ADDR`, 24'h000FFF: last flash address that may be written; must be ≥ `BASE_ADDR`.
- `TIMEOUT_CYCLES`, 100_000_000: maximum wait for `write_done`/`read_done` (2 s at 50 MHz).

Ports:
- `sclk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  8  byte to log.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  byte accepted on a cycle where `in_valid & in_ready`.
- `rd_req`  in  1  readback request, sampled when `rd_ready`=1.
- `rd_addr`  in  24  readback address, captured with `rd_req`.
- `rd_ready`  out  1  no readback pending or in flight, and not faulted.
- `rd_data`  out  8  readback byte.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid.
- `fifo_level`  out  log2(FIFO_DEPTH)+1  bytes buffered.
- `next_addr`  out  24  address of the next write.
- `region_full`  out  1  sticky; `END_ADDR` has been written.
- `err_timeout`  out  1  sticky; the flash controller did not answer in time.
- `flash_addr`  out  24  to controller.
- `write_byte`  out  8  to controller.
- `write_trigger`  out  1  to controller, one-cycle pulse.
- `read_trigger`  out  1  to controller, one-cycle pulse.
- `write_done`  in  1  from controller, one-cycle pulse.
- `read_done`  in  1  from controller, one-cycle pulse; `read_byte` is valid in the same cycle.
- `read_byte`  in  8  from controller.

## Operation
- FIFO:
  - Push when `in_valid & in_ready`. Pop on the `write_done` cycle.
  - Simultaneous push and pop leaves `fifo_level` unchanged.
  - `in_ready` = (`fifo_level` < FIFO_DEPTH) & !`region_full` & !`err_timeout`.
- Read request: a pending-read flag and the captured address are set when `rd_req & rd_ready`.
- FSM states: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, FAULT.
- IDLE:
  - If a read is pending, go to RD_ISSUE. Reads have priority over writes.
  - Otherwise, if `fifo_level`>0 and !`region_full`, go to WR_ISSUE.
- WR_ISSUE: register `flash_addr`=`next_addr` and `write_byte`=FIFO head, pulse `write_trigger`, go to WR_WAIT.
- WR_WAIT: on `write_done`, pop the FIFO and go to IDLE.
  - If the written address was `END_ADDR`, set `region_full` and discard remaining FIFO contents (`fifo_level`→0).
  - Otherwise `next_addr` increments by 1.
- RD_ISSUE: register `flash_addr`=captured address, pulse `read_trigger`, go to RD_WAIT.
- RD_WAIT: on `read_done`, latch `rd_data`=`read_byte`, clear the pending flag, go to IDLE.
- Timeout: a wait counter runs in WR_WAIT/RD_WAIT. If it reaches TIMEOUT_CYCLES, set `err_timeout` and enter FAULT.
- FAULT: no triggers, `in_ready`=0, `rd_ready`=0. Exit only by reset.
- `write_done`/`read_done` arriving in any state other than the matching WAIT state is ignored.
- `write_trigger` and `read_trigger` are never high together.

## Timing
- Reset values: all outputs 0, except `next_addr`=`BASE_ADDR`, `flash_addr`=`BASE_ADDR` and `rd_data`=8'hFF. FIFO is empty, state is IDLE.
- Reset mid-transaction abandons the transaction; no retry after reset.
- `flash_addr`/`write_byte` are stable from the trigger cycle through the done cycle. The controller samples them at several points of its sequence.
- Triggers are spaced at least 2 cycles after the previous done, because the path passes through IDLE. The controller ignores triggers while it is busy.
- `rd_valid` is asserted exactly one cycle after `read_done`, with `rd_data` updated on the same edge.
- `rd_ready` rises the same cycle as `rd_valid`.
- `next_addr` and `fifo_level` update the cycle after `write_done`.
- Write latency is about 0.75 s per byte at default controller settings. The FIFO absorbs bursts.

## Test plan
- Push 3 bytes A5,3C,F0 after reset with a stub controller (`write_done` 20 cycles after trigger) -> three `write_trigger` pulses at addrs 0,1,2 with matching `write_byte`; `next_addr`=3; `fifo_level`=0.
- Push 17 bytes back-to-back, FIFO_DEPTH=16, stub stalled -> `in_ready` drops after the 16th accept; the 17th is held until the first `write_done`.
- `rd_req` at addr 24'h000123 while a write is in WR_WAIT -> `read_trigger` fires only after that `write_done`, ahead of the queued writes; stub `read_byte`=5A -> `rd_valid` pulse with `rd_data`=5A.
- END_ADDR=BASE_ADDR+1, push 4 bytes -> exactly 2 writes; `region_full`=1; `fifo_level`=0; `in_ready`=0.
- TIMEOUT_CYCLES=100, stub never answers -> `err_timeout`=1 at cycle 100 of WR_WAIT; no further triggers; `rst` pulse clears all state.

Source files
------------

// File: rtl/flash_byte_logger.sv
// flash_byte_logger: buffers incoming bytes and commits each one to flash at an
// auto-incrementing address, serving random-address readbacks between writes.
module flash_byte_logger #(
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter logic [23:0] BASE_ADDR      = 24'h000000,
   parameter logic [23:0] END_ADDR       = 24'h000FFF,
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
   input  logic                        sclk,
   input  logic                        rst,
   input  logic [7:0]                  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        rd_req,
   input  logic [23:0]                 rd_addr,
   output logic                        rd_ready,
   output logic [7:0]                  rd_data,
   output logic                        rd_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [23:0]                 next_addr,
   output logic                        region_full,
   output logic                        err_timeout,
   output logic [23:0]                 flash_addr,
   output logic [7:0]                  write_byte,
   output logic                        write_trigger,
   output logic                        read_trigger,
   input  logic                        write_done,
   input  logic                        read_done,
   input  logic [7:0]                  read_byte
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, FAULT
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [23:0]     next_addr_q, flash_addr_q, rd_addr_q;
   logic [7:0]      write_byte_q, rd_data_q;
   logic            rd_valid_q, region_full_q, err_q, rd_pend_q;
   logic [CW-1:0]   cnt_q;

   logic            push, wr_commit, rd_commit, last_write, timeout_hit;

   assign in_ready    = (level_q < LW'(FIFO_DEPTH)) & ~region_full_q & ~err_q;
   assign rd_ready    = ~rd_pend_q & ~err_q;
   assign push        = in_valid & in_ready;
   assign wr_commit   = (state_q == WR_WAIT) & write_done;
   assign rd_commit   = (state_q == RD_WAIT) & read_done;
   assign last_write  = wr_commit & (flash_addr_q == END_ADDR);
   assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   assign fifo_level  = level_q;
   assign next_addr   = next_addr_q;
   assign flash_addr  = flash_addr_q;
   assign write_byte  = write_byte_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign region_full = region_full_q;
   assign err_timeout = err_q;

   // State register
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and trigger decode; reads win over writes when both are ready
   always_comb begin
      state_d       = state_q;
      write_trigger = 1'b0;
      read_trigger  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_pend_q)                              state_d = RD_ISSUE;
            else if ((level_q != '0) && !region_full_q) state_d = WR_ISSUE;
         end
         WR_ISSUE: begin
            write_trigger = 1'b1;
            state_d       = WR_WAIT;
         end
         WR_WAIT: begin
            if (write_done)       state_d = IDLE;
            else if (timeout_hit) state_d = FAULT;
         end
         RD_ISSUE: begin
            read_trigger = 1'b1;
            state_d      = RD_WAIT;
         end
         RD_WAIT: begin
            if (read_done)        state_d = IDLE;
            else if (timeout_hit) state_d = FAULT;
         end
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   // FIFO pointer/level next state; committing END_ADDR flushes whatever is left
   always_comb begin
      wptr_d = push ? wptr_q + AW'(1) : wptr_q;
      if (last_write) begin
         rptr_d  = wptr_d;
         level_d = '0;
      end else begin
         rptr_d  = wr_commit ? rptr_q + AW'(1) : rptr_q;
         level_d = level_q + LW'(push) - LW'(wr_commit);
      end
   end

   // FIFO control registers
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // FIFO storage, data only
   always_ff @(posedge sclk) begin
      if (push) fifo_mem_q[wptr_q] <= in_data;
   end

   // Controller address/data are loaded on entry to an ISSUE state and then held
   // untouched until the transaction's done pulse
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         flash_addr_q <= BASE_ADDR;
         write_byte_q <= 8'h00;
      end else if (state_q == IDLE && state_d == WR_ISSUE) begin
         flash_addr_q <= next_addr_q;
         write_byte_q <= fifo_mem_q[rptr_q];
      end else if (state_q == IDLE && state_d == RD_ISSUE) begin
         flash_addr_q <= rd_addr_q;
      end
   end

   // Write commit bookkeeping: address advance or sticky region-full
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         next_addr_q   <= BASE_ADDR;
         region_full_q <= 1'b0;
      end else if (last_write) begin
         region_full_q <= 1'b1;
      end else if (wr_commit) begin
         next_addr_q   <= next_addr_q + 24'd1;
      end
   end

   // Readback request capture and response; rd_ready returns with rd_valid
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         rd_pend_q  <= 1'b0;
         rd_addr_q  <= 24'h000000;
         rd_data_q  <= 8'hFF;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_commit;
         if (rd_req && rd_ready) begin
            rd_pend_q <= 1'b1;
            rd_addr_q <= rd_addr;
         end else if (rd_commit) begin
            rd_pend_q <= 1'b0;
         end
         if (rd_commit) rd_data_q <= read_byte;
      end
   end

   // Wait-state watchdog; a silent controller parks the block in FAULT
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if ((state_q == WR_WAIT || state_q == RD_WAIT) && !wr_commit && !rd_commit)
            cnt_q <= cnt_q + CW'(1);
         else
            cnt_q <= '0;
         if (state_d == FAULT) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_flash_byte_logger.sv
// Directed bench for flash_byte_logger with a behavioural flash-controller stub.
module tb_flash_byte_logger;

   logic        sclk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        rd_req;
   logic [23:0] rd_addr;
   logic        rd_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [4:0]  fifo_level;
   logic [23:0] next_addr;
   logic        region_full;
   logic        err_timeout;
   logic [23:0] flash_addr;
   logic [7:0]  write_byte;
   logic        write_trigger;
   logic        read_trigger;
   logic        write_done;
   logic        read_done;
   logic [7:0]  read_byte;

   int total = 0;
   int bad   = 0;

   // stub controls
   int         stub_delay = 19;
   logic       stub_hang  = 1'b0;
   logic [7:0] stub_rbyte = 8'h00;

   flash_byte_logger #(
      .FIFO_DEPTH(16), .BASE_ADDR(24'h000010), .END_ADDR(24'h000028), .TIMEOUT_CYCLES(100)
   ) dut (
      .sclk(sclk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_valid(rd_valid), .fifo_level(fifo_level), .next_addr(next_addr),
      .region_full(region_full), .err_timeout(err_timeout), .flash_addr(flash_addr),
      .write_byte(write_byte), .write_trigger(write_trigger), .read_trigger(read_trigger),
      .write_done(write_done), .read_done(read_done), .read_byte(read_byte)
   );

   always #5 sclk = ~sclk;

   // controller stub: done pulse stub_delay+1 cycles after trigger, triggers ignored while busy
   logic stub_busy;
   logic stub_is_rd;
   int   stub_cnt;
   always @(posedge sclk or posedge rst) begin
      if (rst) begin
         stub_busy <= 1'b0; stub_is_rd <= 1'b0; stub_cnt <= 0;
         write_done <= 1'b0; read_done <= 1'b0; read_byte <= 8'h00;
      end else begin
         write_done <= 1'b0;
         read_done  <= 1'b0;
         if (!stub_busy) begin
            if (write_trigger || read_trigger) begin
               stub_busy  <= 1'b1;
               stub_is_rd <= read_trigger;
               stub_cnt   <= stub_delay;
            end
         end else if (!stub_hang) begin
            if (stub_cnt <= 1) begin
               stub_busy <= 1'b0;
               if (stub_is_rd) begin
                  read_done <= 1'b1;
                  read_byte <= stub_rbyte;
               end else begin
                  write_done <= 1'b1;
               end
            end else begin
               stub_cnt <= stub_cnt - 1;
            end
         end
      end
   end

   // trigger log and protocol monitors
   logic [23:0] ev_addr [64];
   logic [7:0]  ev_byte [64];
   logic        ev_rd   [64];
   int          ev_n, wd_n, both_n, unstable_n;
   logic [23:0] hold_addr;
   logic [7:0]  hold_byte;
   always @(posedge sclk or posedge rst) begin
      if (rst) begin
         ev_n <= 0; wd_n <= 0; both_n <= 0; unstable_n <= 0;
         hold_addr <= 24'h0; hold_byte <= 8'h0;
      end else begin
         if (write_trigger && read_trigger) both_n <= both_n + 1;
         if (write_trigger || read_trigger) begin
            if (ev_n < 64) begin
               ev_addr[ev_n] <= flash_addr;
               ev_byte[ev_n] <= write_byte;
               ev_rd[ev_n]   <= read_trigger;
            end
            ev_n      <= ev_n + 1;
            hold_addr <= flash_addr;
            hold_byte <= write_byte;
         end else if (stub_busy && (flash_addr !== hold_addr ||
                                    (!stub_is_rd && write_byte !== hold_byte))) begin
            unstable_n <= unstable_n + 1;
         end
         if (write_done) wd_n <= wd_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // leaves in_valid high; returns on the negedge after the accepting edge
   task automatic push(input logic [7:0] b);
      int n;
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 400) begin
         @(negedge sclk);
         n++;
      end
      chk("push_accept", in_ready, 1'b1);
      @(negedge sclk);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; rd_req = 1'b0; rd_addr = 24'h0;
      repeat (3) @(negedge sclk);
      chk("rst_next_addr",  next_addr,     24'h000010);
      chk("rst_flash_addr", flash_addr,    24'h000010);
      chk("rst_rd_data",    rd_data,       8'hFF);
      chk("rst_level",      fifo_level,    5'd0);
      chk("rst_wbyte",      write_byte,    8'h00);
      chk("rst_trig",       {write_trigger, read_trigger, rd_valid}, 3'b000);
      chk("rst_sticky",     {region_full, err_timeout}, 2'b00);
      rst = 1'b0;
      @(negedge sclk);
      chk("rst_ready", {in_ready, rd_ready}, 2'b11);

      // three bytes, sequential addresses
      stub_delay = 19;
      push(8'hA5); push(8'h3C); push(8'hF0);
      in_valid = 1'b0;
      n = 0;
      while (next_addr != 24'h000013 && n < 300) begin @(negedge sclk); n++; end
      @(negedge sclk);
      chk("a_next_addr", next_addr, 24'h000013);
      chk("a_level",     fifo_level, 5'd0);
      chk("a_ev_n",      ev_n, 3);
      chk("a_addr0", ev_addr[0], 24'h000010);
      chk("a_addr1", ev_addr[1], 24'h000011);
      chk("a_addr2", ev_addr[2], 24'h000012);
      chk("a_byte0", ev_byte[0], 8'hA5);
      chk("a_byte1", ev_byte[1], 8'h3C);
      chk("a_byte2", ev_byte[2], 8'hF0);

      // readback requested while a write is outstanding
      push(8'h11); push(8'h22); push(8'h33);
      in_valid = 1'b0;
      n = 0;
      while (ev_n < 4 && n < 100) begin @(negedge sclk); n++; end
      chk("b_wr_started", ev_n, 4);
      chk("b_rd_ready_pre", rd_ready, 1'b1);
      rd_req = 1'b1; rd_addr = 24'h000123; stub_rbyte = 8'h5A;
      @(negedge sclk);
      rd_req = 1'b0;
      chk("b_rd_ready_busy", rd_ready, 1'b0);
      n = 0;
      while (!rd_valid && n < 300) begin @(negedge sclk); n++; end
      chk("b_rd_valid", rd_valid, 1'b1);
      chk("b_rd_data",  rd_data, 8'h5A);
      chk("b_rd_ready_back", rd_ready, 1'b1);
      chk("b_ev_n_at_read", ev_n, 5);
      chk("b_wd_before_read", wd_n, 4);
      chk("b_ev4_is_read", ev_rd[4], 1'b1);
      chk("b_ev4_addr", ev_addr[4], 24'h000123);
      @(negedge sclk);
      chk("b_rd_valid_pulse", rd_valid, 1'b0);
      n = 0;
      while (next_addr != 24'h000016 && n < 300) begin @(negedge sclk); n++; end
      @(negedge sclk);
      chk("b_next_addr", next_addr, 24'h000016);
      chk("b_ev_n", ev_n, 7);
      chk("b_ev6_addr", ev_addr[6], 24'h000015);
      chk("b_ev6_byte", ev_byte[6], 8'h33);
      chk("b_ev6_wr",   ev_rd[6], 1'b0);

      // 17 back-to-back bytes against a slow controller
      stub_delay = 90;
      for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
      in_data = 8'h50;
      chk("c_full_ready", in_ready, 1'b0);
      chk("c_full_level", fifo_level, 5'd16);
      n = 0;
      while (!in_ready && n < 200) begin @(negedge sclk); n++; end
      chk("c_ready_back", in_ready, 1'b1);
      chk("c_ready_after_done", wd_n, 7);
      chk("c_level_15", fifo_level, 5'd15);
      @(negedge sclk);
      in_valid = 1'b0;
      chk("c_level_after_17", fifo_level, 5'd16);
      n = 0;
      while (next_addr != 24'h000027 && n < 3000) begin @(negedge sclk); n++; end
      @(negedge sclk);
      chk("c_next_addr", next_addr, 24'h000027);
      chk("c_ev_n", ev_n, 24);
      chk("c_last_addr", ev_addr[23], 24'h000026);
      chk("c_last_byte", ev_byte[23], 8'h50);
      chk("c_level", fifo_level, 5'd0);

      // region end reached after two of four bytes
      stub_delay = 19;
      push(8'h61); push(8'h62); push(8'h63); push(8'h64);
      in_valid = 1'b0;
      n = 0;
      while (!region_full && n < 300) begin @(negedge sclk); n++; end
      repeat (5) @(negedge sclk);
      chk("d_region_full", region_full, 1'b1);
      chk("d_level", fifo_level, 5'd0);
      chk("d_in_ready", in_ready, 1'b0);
      chk("d_ev_n", ev_n, 26);
      chk("d_addr_end", ev_addr[25], 24'h000028);
      chk("d_byte_end", ev_byte[25], 8'h62);
      chk("d_next_addr", next_addr, 24'h000028);
      chk("both_triggers", both_n, 0);
      chk("addr_stability", unstable_n, 0);

      // watchdog on a silent controller
      rst = 1'b1;
      repeat (2) @(negedge sclk);
      rst = 1'b0;
      @(negedge sclk);
      chk("e_rst_region", region_full, 1'b0);
      chk("e_rst_next", next_addr, 24'h000010);
      chk("e_rst_ready", in_ready, 1'b1);
      stub_hang = 1'b1;
      push(8'h77);
      in_valid = 1'b0;
      n = 0;
      while (!write_trigger && n < 50) begin @(negedge sclk); n++; end
      chk("e_trigger", write_trigger, 1'b1);
      repeat (100) @(negedge sclk);
      chk("e_err_c100", err_timeout, 1'b0);
      @(negedge sclk);
      chk("e_err_set", err_timeout, 1'b1);
      chk("e_fault_ready", {in_ready, rd_ready}, 2'b00);
      in_valid = 1'b1; rd_req = 1'b1; rd_addr = 24'h000200;
      repeat (30) @(negedge sclk);
      chk("e_no_triggers", ev_n, 1);
      chk("e_err_sticky", err_timeout, 1'b1);
      in_valid = 1'b0; rd_req = 1'b0; stub_hang = 1'b0;
      rst = 1'b1;
      @(negedge sclk);
      rst = 1'b0;
      @(negedge sclk);
      chk("e_clr_err", err_timeout, 1'b0);
      chk("e_clr_level", fifo_level, 5'd0);
      chk("e_clr_ready", {in_ready, rd_ready}, 2'b11);
      chk("e_clr_flash_addr", flash_addr, 24'h000010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
